led_bcd_display: RTL and testbench

//   Downstream display stage for the picoMips core.
//   - Takes the signed 8-bit LED bus (accumulator) and converts it to sign + 3 BCD digits.
//   - Conversion is a sequential double-dabble, one bit per clock.
//   - Drives four active-low 7-segment digits (HEX3 = sign, HEX2..HEX0 = hundreds/tens/units).
//   - Conversion starts only after the input has been stable, so ALU transients do not flicker the display.
//

---
 rtl/led_bcd_display.sv | 131 +++++++++++++
 tb/tb_led_bcd_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_bcd_display.sv
// Signed 8-bit value to sign + 3-digit active-low 7-segment display via sequential double-dabble.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module led_bcd_display #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] value,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       busy,
  output logic       valid
);
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [3:0] STAB  = 4'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] ZERO  = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_RST = BLANK;
`else
  localparam logic [6:0] LEAD_RST = ZERO;
`endif

  state_t      state, next_state;
  logic [7:0]  in_q, shown_q, tgt, mag;
  logic [3:0]  stab_cnt;
  logic [11:0] bcd, bcd_adj;
  logic [2:0]  bitcnt;
  logic        neg, start;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    adj = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign start   = (in_q != shown_q) && (stab_cnt >= STAB);
  assign bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};

  // Input sampling and stability counter run regardless of FSM state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      in_q     <= '0;
      stab_cnt <= '0;
    end else begin
      in_q     <= value;
      stab_cnt <= (value != in_q) ? 4'd0 : ((stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (bitcnt == 3'd7) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == IDLE) && (in_q == shown_q);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      neg     <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      tgt     <= '0;
      bitcnt  <= '0;
      shown_q <= '0;
      HEX0    <= ZERO;
      HEX1    <= LEAD_RST;
      HEX2    <= LEAD_RST;
      HEX3    <= BLANK;
    end else begin
      case (state)
        IDLE: if (start) begin
          neg    <= in_q[7];
          mag    <= in_q[7] ? (~in_q + 8'd1) : in_q;
          bcd    <= '0;
          tgt    <= in_q;
          bitcnt <= '0;
        end
        SHIFT: begin
          bcd    <= {bcd_adj[10:0], mag[7]};
          mag    <= {mag[6:0], 1'b0};
          bitcnt <= bitcnt + 3'd1;
        end
        UPDATE: begin
          HEX0    <= seg(bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
          HEX1    <= (bcd[11:4] == 8'd0) ? BLANK : seg(bcd[7:4]);
          HEX2    <= (bcd[11:8] == 4'd0) ? BLANK : seg(bcd[11:8]);
`else
          HEX1    <= seg(bcd[7:4]);
          HEX2    <= seg(bcd[11:8]);
`endif
          HEX3    <= neg ? MINUS : BLANK;
          shown_q <= tgt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_led_bcd_display.sv
// Bench for led_bcd_display: directed scenarios plus random stimulus against a timing/arithmetic model.
module tb_led_bcd_display;
  localparam int S = 2;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       busy, valid;

  int checks = 0;
  int errors = 0;

  led_bcd_display #(.STABLE_CYCLES(S)) dut (
    .Clock(Clock), .nReset(nReset), .value(value),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .busy(busy), .valid(valid)
  );

  always #5 Clock = ~Clock;

  localparam logic [6:0] BL = 7'h7F;
  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Expected {HEX3,HEX2,HEX1,HEX0} for a displayed value, from plain decimal arithmetic.
  function automatic logic [27:0] disp(input logic [7:0] v);
    int s, m, h, t, u;
    logic [6:0] d2, d1;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    h = m / 100; t = (m / 10) % 10; u = m % 10;
    d2 = SEG[h]; d1 = SEG[t];
    if (LZB && h == 0) d2 = BL;
    if (LZB && h == 0 && t == 0) d1 = BL;
    return {((s < 0) ? 7'h3F : BL), d2, d1, SEG[u]};
  endfunction

  // Model: sampled input, stability count, and an edge countdown to the display update.
  logic [7:0] m_in, m_shown, m_tgt;
  int         m_stab, m_cnt;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_in <= 8'd0; m_shown <= 8'd0; m_tgt <= 8'd0; m_stab <= 0; m_cnt <= 0;
    end else begin
      if (m_cnt == 0) begin
        if (m_in != m_shown && m_stab >= S) begin
          m_tgt <= m_in;
          m_cnt <= 9;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_shown <= m_tgt;
      end
      m_stab <= (value != m_in) ? 0 : ((m_stab == 15) ? 15 : m_stab + 1);
      m_in   <= value;
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    logic [27:0] e;
    if (nReset) begin
      e = disp(m_shown);
      chk("HEX3", HEX3, e[27:21]);
      chk("HEX2", HEX2, e[20:14]);
      chk("HEX1", HEX1, e[13:7]);
      chk("HEX0", HEX0, e[6:0]);
      chk("busy", {6'd0, busy}, {6'd0, m_cnt != 0});
      chk("valid", {6'd0, valid}, {6'd0, (m_cnt == 0) && (m_in == m_shown)});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic chk_hex(input string name, input logic [27:0] exp);
    chk({name, "_h3"}, HEX3, exp[27:21]);
    chk({name, "_h2"}, HEX2, exp[20:14]);
    chk({name, "_h1"}, HEX1, exp[13:7]);
    chk({name, "_h0"}, HEX0, exp[6:0]);
  endtask

  logic [6:0] lead0;

  initial begin
    lead0 = LZB ? BL : 7'h40;
    #12 nReset = 1'b1;
    step(1);
    // Reset state
    chk_hex("reset", {BL, lead0, lead0, 7'h40});
    chk("reset_busy", {6'd0, busy}, 7'd0);
    chk("reset_valid", {6'd0, valid}, 7'd1);

    // 127: busy at edge 4, display at edge 13
    value = 8'd127;
    step(3);
    chk("b127_e3", {6'd0, busy}, 7'd0);
    step(1);
    chk("b127_e4", {6'd0, busy}, 7'd1);
    step(9);
    chk_hex("v127", {BL, 7'h79, 7'h24, 7'h78});
    chk("v127_valid", {6'd0, valid}, 7'd1);

    // -128 and -5
    value = 8'h80;
    step(14);
    chk_hex("vm128", {7'h3F, 7'h79, 7'h24, 7'h00});
    value = 8'hFB;
    step(14);
    chk_hex("vm5", {7'h3F, lead0, lead0, 7'h12});

    // Toggling input never displays until it settles
    for (int i = 0; i < 10; i++) begin
      value = (i % 2 == 0) ? 8'd3 : 8'd9;
      step(1);
    end
    value = 8'd42;
    step(16);
    chk_hex("v42", {BL, lead0, 7'h19, 7'h24});

    // Change during conversion
    value = 8'd10;
    step(4);
    step(3);
    value = 8'd99;
    step(30);
    chk_hex("v99", {BL, lead0, 7'h10, 7'h10});

    // Reset mid-conversion
    value = 8'd100;
    step(6);
    #1 nReset = 1'b0;
    #1;
    chk_hex("rst_mid", {BL, lead0, lead0, 7'h40});
    chk("rst_mid_busy", {6'd0, busy}, 7'd0);
    @(posedge Clock);
    #2 nReset = 1'b1;
    step(14);
    chk_hex("v100", {BL, 7'h79, 7'h40, 7'h40});

    // Random stimulus against the model
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0: value = 8'($urandom_range(0, 255));
        1: value = 8'($urandom_range(0, 3));
        2: value = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
        default: value = 8'($urandom_range(250, 255));
      endcase
      step($urandom_range(1, 16));
    end
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
